// File: rtl/up_seq_core.sv
// up_seq_core -- accumulator micro-sequencer with a handshaked memory port.
//
// Each instruction is two memory words: an opcode word followed by a value
// word. FETCH_U reads the opcode, FETCH_L reads the value, and EXEC performs
// the operation. Memory-operand ops make one extra access in EXEC. An illegal
// opcode parks the core in HALT until reset.
//
// Parameters:
//   DATA_W  accumulator / memory word / instruction field width (8..32)
//   ADDR_W  memory address and pc width (4..DATA_W)
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   mem_req    access request, held until mem_ack
//   mem_we     write qualifier, valid while mem_req=1
//   mem_addr   access address
//   mem_wdata  store data (always ac)
//   mem_rdata  read data, valid in the cycle mem_ack=1
//   mem_ack    completes the pending access in the same cycle
//   step       single-step pulse (only with UP_SEQ_STEP_EN)
//   pc, opcode, value, ac, nflg, zflg, cflg   architectural registers
//   halted     1 only while in HALT
//
// Build option: define UP_SEQ_STEP_EN to gate each opcode fetch on a prior
// step pulse. Without it, step is ignored and fetch runs freely.

module up_seq_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic              step,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] opcode,
  output logic [DATA_W-1:0] value,
  output logic [DATA_W-1:0] ac,
  output logic              nflg,
  output logic              zflg,
  output logic              cflg,
  output logic              halted
);

  typedef enum logic [1:0] {S_FETCH_U, S_FETCH_L, S_EXEC, S_HALT} state_e;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_JUMP  = 4'h3;
  localparam logic [3:0] OP_JNEG  = 4'h4;
  localparam logic [3:0] OP_SUB   = 4'h5;
  localparam logic [3:0] OP_XOR   = 4'h6;
  localparam logic [3:0] OP_OR    = 4'h7;
  localparam logic [3:0] OP_AND   = 4'h8;
  localparam logic [3:0] OP_JZERO = 4'h9;
  localparam logic [3:0] OP_ADDI  = 4'hA;
  localparam logic [3:0] OP_LDI   = 4'hB;
  localparam logic [3:0] OP_SHL   = 4'hC;
  localparam logic [3:0] OP_SHR   = 4'hD;

  state_e              r_state, w_next;
  logic [ADDR_W-1:0]   r_pc;
  logic [DATA_W-1:0]   r_opcode, r_value, r_ac;
  logic                r_n, r_z, r_c;

  logic [3:0]          w_op;
  logic                w_legal, w_memop, w_go, w_req, w_fire, w_done;
  logic                w_wr_ac, w_jump, w_c_nx;
  logic [DATA_W-1:0]   w_ac_nx, w_add_b;
  logic [DATA_W:0]     w_sum, w_diff;
  logic [ADDR_W-1:0]   w_opnd_addr;

  // ---------------------------------------------------------------- decode
  assign w_op        = r_opcode[3:0];
  assign w_legal     = (r_opcode[DATA_W-1:4] == '0) && (w_op <= OP_SHR);
  assign w_memop     = w_legal && (w_op inside {OP_ADD, OP_STORE, OP_LOAD,
                                                OP_SUB, OP_XOR, OP_OR, OP_AND});
  assign w_opnd_addr = r_value[ADDR_W-1:0];

  // ADD and ADDI share one adder; the extra top bit is the carry-out.
  assign w_add_b = (w_op == OP_ADDI) ? r_value : mem_rdata;
  assign w_sum   = {1'b0, r_ac} + {1'b0, w_add_b};
  // Top bit of the widened difference is the borrow.
  assign w_diff  = {1'b0, r_ac} - {1'b0, mem_rdata};

`ifdef UP_SEQ_STEP_EN
  // Armed by a step pulse, disarmed when an instruction completes; a pulse
  // coinciding with completion arms the next instruction.
  logic r_armed;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_armed <= 1'b0;
    else if (step)   r_armed <= 1'b1;
    else if (w_done) r_armed <= 1'b0;
  end

  assign w_go = r_armed;
`else
  logic w_unused_step;
  assign w_unused_step = step;
  assign w_go          = 1'b1;
`endif

  assign w_fire = mem_req && mem_ack;
  assign w_done = (r_state == S_EXEC) && w_legal && (!w_memop || mem_ack);

  // ------------------------------------------------------- state register
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!reset) r_state <= S_FETCH_U;
    else        r_state <= w_next;
  end

  // ----------------------------------------------------------- next state
  always_comb begin
    // NOTE: default first so no path leaves w_next unassigned (no latch).
    w_next = r_state;
    case (r_state)
      S_FETCH_U: if (w_fire) w_next = S_FETCH_L;
      S_FETCH_L: if (w_fire) w_next = S_EXEC;
      S_EXEC: begin
        if (!w_legal)    w_next = S_HALT;
        else if (w_done) w_next = S_FETCH_U;
      end
      default:           w_next = S_HALT;
    endcase
  end

  // --------------------------------------------------------------- outputs
  // The request is gated by reset so it drops the moment reset asserts,
  // even mid-access, and rises as soon as reset releases.
  always_comb begin
    w_req = 1'b0;
    case (r_state)
      S_FETCH_U: w_req = w_go;
      S_FETCH_L: w_req = 1'b1;
      S_EXEC:    w_req = w_memop;
      default:   w_req = 1'b0;
    endcase
    mem_req   = w_req & reset;
    mem_we    = (r_state == S_EXEC) & w_memop & (w_op == OP_STORE) & reset;
    mem_addr  = (r_state == S_EXEC) ? w_opnd_addr : r_pc;
    mem_wdata = r_ac;
    halted    = (r_state == S_HALT);
  end

  // ------------------------------------------------------------- execute
  always_comb begin
    w_ac_nx = r_ac;
    w_c_nx  = r_c;
    w_wr_ac = 1'b0;
    w_jump  = 1'b0;
    case (w_op)
      OP_ADD, OP_ADDI: begin {w_c_nx, w_ac_nx} = w_sum;  w_wr_ac = 1'b1; end
      OP_SUB:          begin {w_c_nx, w_ac_nx} = w_diff; w_wr_ac = 1'b1; end
      OP_LOAD:         begin w_ac_nx = mem_rdata;        w_wr_ac = 1'b1; end
      OP_XOR:          begin w_ac_nx = r_ac ^ mem_rdata; w_wr_ac = 1'b1; end
      OP_OR:           begin w_ac_nx = r_ac | mem_rdata; w_wr_ac = 1'b1; end
      OP_AND:          begin w_ac_nx = r_ac & mem_rdata; w_wr_ac = 1'b1; end
      OP_LDI:          begin w_ac_nx = r_value;          w_wr_ac = 1'b1; end
      OP_SHL:          begin {w_c_nx, w_ac_nx} = {r_ac, 1'b0}; w_wr_ac = 1'b1; end
      OP_SHR:          begin {w_ac_nx, w_c_nx} = {1'b0, r_ac}; w_wr_ac = 1'b1; end
      OP_JUMP:         w_jump = 1'b1;
      OP_JNEG:         w_jump = r_n;
      OP_JZERO:        w_jump = r_z;
      default:         ;
    endcase
  end

  // ------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc     <= '0;
      r_opcode <= '0;
      r_value  <= '0;
      r_ac     <= '0;
      r_n      <= 1'b0;
      r_z      <= 1'b0;
      r_c      <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH_U: if (w_fire) begin
          r_opcode <= mem_rdata;
          r_pc     <= r_pc + 1'b1;
        end
        S_FETCH_L: if (w_fire) begin
          r_value <= mem_rdata;
          r_pc    <= r_pc + 1'b1;
        end
        S_EXEC: if (w_done) begin
          if (w_wr_ac) begin
            r_ac <= w_ac_nx;
            r_n  <= w_ac_nx[DATA_W-1];
            r_z  <= (w_ac_nx == '0);
          end
          r_c <= w_c_nx;
          if (w_jump) r_pc <= w_opnd_addr;
        end
        default: ;
      endcase
    end
  end

  assign pc     = r_pc;
  assign opcode = r_opcode;
  assign value  = r_value;
  assign ac     = r_ac;
  assign nflg   = r_n;
  assign zflg   = r_z;
  assign cflg   = r_c;

endmodule
